// File: rtl/rv_pkg.sv
// Shared RISC-V MEM-stage definitions: load/store funct3 encodings, LSU FSM
// states, and the width/offset rules shared by the LSU datapath.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // Unknown widths fault like misaligned accesses so they never reach the bus.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f3_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return 4'b0001 << off;
      F3_H, F3_HU: return 4'b0011 << off;
      default:     return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the byte/half/word at a byte offset from a raw memory word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = lane;
    case (funct3)
      F3_B:    data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_BU:   data = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_H:    data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_HU:   data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: request/grant/response handshake with data
// memory, store lane steering, load extraction, and pipeline stall.
module mem_lsu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic            memread,
  input  logic            memwrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            resp_valid,
  output logic            misaligned,
  output logic [XLEN-1:0] read_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic            is_load_q;
  logic            start;
  logic [XLEN-1:0] load_data;

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] sd);
    case (f3)
      F3_B:    return {(XLEN/8){sd[7:0]}};
      F3_H:    return {(XLEN/16){sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  assign start = op_valid & (memread | memwrite);
  assign stall = ((state == IDLE) && start) || (state == REQ) || (state == WAIT);

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (funct3_q),
    .offset (off_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      is_load_q  <= 1'b0;
      resp_valid <= 1'b0;
      misaligned <= 1'b0;
      read_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (f3_misaligned(funct3, addr[1:0])) begin
              misaligned <= 1'b1;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              funct3_q  <= funct3;
              off_q     <= addr[1:0];
              is_load_q <= memread;
              mem_req   <= 1'b1;
              mem_we    <= ~memread;
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_be    <= f3_byte_en(funct3, addr[1:0]);
              mem_wdata <= store_lanes(funct3, store_data);
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (!is_load_q) begin
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (mem_rvalid) begin
              read_data  <= load_data;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            read_data  <= load_data;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          // A request presented now waits for the next IDLE cycle.
          resp_valid <= 1'b0;
          misaligned <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases, reset mid-access, and
// randomized loads/stores against a behavioural memory-side model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, memread, memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, resp_valid, misaligned;
  logic [31:0] read_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .memread    (memread),
    .memwrite   (memwrite),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .resp_valid (resp_valid),
    .misaligned (misaligned),
    .read_data  (read_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_mis(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return off[0];
    if (f3 == 3'd2) return off != 2'd0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> (8 * off);
    case (f3)
      3'd0:    return lane[7]  ? ((lane & 32'hFF)   | 32'hFFFF_FF00) : (lane & 32'hFF);
      3'd4:    return lane & 32'hFF;
      3'd1:    return lane[15] ? ((lane & 32'hFFFF) | 32'hFFFF_0000) : (lane & 32'hFFFF);
      3'd5:    return lane & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // gd: REQ cycles before gnt; rd: -1 = rvalid with gnt, else WAIT cycles until rvalid.
  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int gd, input int rd,
                       input logic [31:0] rw, input string tag);
    bit          mis, done, granted, req_seen;
    int          stall_n, req_n, wait_n, exp_stall;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    mis = model_mis(f3, a[1:0]);
    if (f3 == 3'd0 || f3 == 3'd4)      ebe = 4'd1 << a[1:0];
    else if (f3 == 3'd1 || f3 == 3'd5) ebe = 4'd3 << a[1:0];
    else                               ebe = 4'hF;
    if (f3 == 3'd0)      ewd = (sd & 32'hFF) * 32'h0101_0101;
    else if (f3 == 3'd1) ewd = (sd & 32'hFFFF) * 32'h0001_0001;
    else                 ewd = sd;
    exp_stall = mis ? 1 : (2 + gd + ((ld && rd > 0) ? rd : 0));

    @(negedge clk);
    op_valid = 1'b1; memread = ld; memwrite = !ld;
    funct3 = f3; addr = a; store_data = sd;
    #1;
    stall_n = stall ? 1 : 0;
    @(posedge clk);
    #1;
    op_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    done = 0; granted = 0; req_seen = 0; req_n = 0; wait_n = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (resp_valid) done = 1;
      else begin
        if (stall) stall_n++;
        if (mem_req) begin
          req_seen = 1;
          check({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
          check({tag, ".we"}, 32'(mem_we), 32'(!ld));
          check({tag, ".be"}, 32'(mem_be), 32'(ebe));
          if (!ld) check({tag, ".wdata"}, mem_wdata, ewd);
          if (req_n == gd) begin
            mem_gnt = 1'b1;
            granted = 1;
            if (ld && rd < 0) begin mem_rvalid = 1'b1; mem_rdata = rw; end
          end
          req_n++;
        end else if (granted) begin
          wait_n++;
          if (wait_n == rd) begin mem_rvalid = 1'b1; mem_rdata = rw; end
        end
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check({tag, ".resp"}, 32'(done), 32'd1);
    if (done) begin
      if (ld && !mis) exp_rd = model_ext(f3, a[1:0], rw);
      check({tag, ".mis"}, 32'(misaligned), 32'(mis));
      check({tag, ".stall_done"}, 32'(stall), 32'd0);
      check({tag, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));
      check({tag, ".req_seen"}, 32'(req_seen), 32'(!mis));
      check({tag, ".rdata"}, read_data, exp_rd);
      @(negedge clk);
      check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
    funct3 = 3'd0; addr = 32'h0; store_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.resp", 32'(resp_valid), 32'd0);
    check("rst.mis", 32'(misaligned), 32'd0);
    check("rst.rdata", read_data, 32'd0);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.we", 32'(mem_we), 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.be", 32'(mem_be), 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    do_op(0, 3'd2, 32'h0000_1008, 32'hDEAD_BEEF, 2, -1, 32'h0, "sw");
    do_op(0, 3'd0, 32'h0000_1003, 32'h0000_00A5, 0, -1, 32'h0, "sb");
    do_op(1, 3'd0, 32'h0000_2002, 32'h0, 1, 1, 32'h0080_0000, "lb");
    check("lb.value", read_data, 32'hFFFF_FF80);
    do_op(1, 3'd4, 32'h0000_2002, 32'h0, 0, 2, 32'h0080_0000, "lbu");
    check("lbu.value", read_data, 32'h0000_0080);
    do_op(1, 3'd1, 32'h0000_2002, 32'h0, 0, -1, 32'h8001_1234, "lh");
    check("lh.value", read_data, 32'hFFFF_8001);
    do_op(1, 3'd2, 32'h0000_3001, 32'h0, 0, -1, 32'h1234_5678, "lw_mis");
    check("lw_mis.value", read_data, 32'hFFFF_8001);

    // Reset while waiting for load data; the late rvalid must be ignored.
    @(negedge clk);
    op_valid = 1'b1; memread = 1'b1; funct3 = 3'd2; addr = 32'h0000_4000;
    @(posedge clk);
    #1 op_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    check("rstw.req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstw.wait_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'h0;
    check("rstw.stall", 32'(stall), 32'd0);
    check("rstw.rdata", read_data, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstw.resp", 32'(resp_valid), 32'd0);
    check("rstw.rdata2", read_data, 32'd0);
    check("rstw.stall2", 32'(stall), 32'd0);
    check("rstw.req2", 32'(mem_req), 32'd0);

    for (int i = 0; i < 40; i++) begin
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] a;
      int          rd;
      logic [2:0]  ld_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
      logic [2:0]  st_f3 [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_f3[$urandom_range(0, 6)] : st_f3[$urandom_range(0, 3)];
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rd = int'($urandom_range(0, 3));
      if (rd == 0) rd = -1;
      do_op(ld, f3, a, $urandom(), int'($urandom_range(0, 3)), rd, $urandom(), "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
